// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: default parameters,
// the fetch-queue entry layout and PC alignment helper.
package fetch_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam int          FQ_DEPTH_DEF = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        pred_taken;
      logic [31:0] pred_target;
   } fq_entry_t;

   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched instructions with count-based full/empty and a
// single-cycle clear used on branch-misprediction flush.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = FQ_DEPTH_DEF
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      clear,
   input  logic      push,
   input  fq_entry_t push_data,
   input  logic      pop,
   output fq_entry_t head,
   output logic      empty,
   output logic      full
);

   localparam int              PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   fq_entry_t        mem_q [DEPTH];
   fq_entry_t        mem_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == FULL_CNT);
   assign do_pop  = pop && !empty;
   // A push at full is legal only when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign head    = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (clear) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: single-outstanding imem requests steered by the
// branch predictor, a fetch queue feeding decode, and flush/drop recovery.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int          FQ_DEPTH = FQ_DEPTH_DEF
) (
   input  logic        clk,
   input  logic        reset,
   output logic        fetch_valid,
   output logic [31:0] fetch_pc,
   input  logic        predicted_taken,
   input  logic [31:0] predicted_target,
   input  logic        btb_hit,
   input  logic        flush,
   input  logic [31:0] recover_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [31:0] dec_pc,
   output logic [31:0] dec_instr,
   output logic        dec_pred_taken,
   output logic [31:0] dec_pred_target
);

   logic [31:0] pc_q, pc_d;
   logic        outstanding_q, outstanding_d;
   logic        drop_q, drop_d;
   logic [31:0] pend_pc_q, pend_pc_d;
   logic        pend_taken_q, pend_taken_d;
   logic [31:0] pend_target_q, pend_target_d;

   logic        taken, req_fire, q_push, deq, q_empty, q_full;
   fq_entry_t   q_in, q_head;

   assign taken          = predicted_taken && btb_hit;
   assign imem_req_valid = !reset && !flush && !outstanding_q && !drop_q && !q_full;
   assign imem_req_addr  = pc_q;
   assign fetch_valid    = imem_req_valid;
   assign fetch_pc       = pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign q_push         = imem_resp_valid && outstanding_q && !flush;
   assign dec_valid      = !q_empty && !flush;
   assign deq            = dec_valid && dec_ready;

   always_comb begin
      q_in             = '0;
      q_in.pc          = pend_pc_q;
      q_in.instr       = imem_resp_data;
      q_in.pred_taken  = pend_taken_q;
      q_in.pred_target = pend_target_q;
   end

   always_comb begin
      pc_d          = pc_q;
      outstanding_d = outstanding_q;
      drop_d        = drop_q;
      pend_pc_d     = pend_pc_q;
      pend_taken_d  = pend_taken_q;
      pend_target_d = pend_target_q;
      if (flush) begin
         pc_d          = align_pc(recover_pc);
         outstanding_d = 1'b0;
         // A response still owed to the old path must be swallowed later.
         drop_d        = (outstanding_q || drop_q) && !imem_resp_valid;
      end else begin
         if (imem_resp_valid) begin
            outstanding_d = 1'b0;
            drop_d        = 1'b0;
         end
         if (req_fire) begin
            outstanding_d = 1'b1;
            pend_pc_d     = pc_q;
            pend_taken_d  = taken;
            pend_target_d = predicted_target;
            pc_d          = taken ? align_pc(predicted_target) : align_pc(pc_q + 32'd4);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q          <= align_pc(RESET_PC);
         outstanding_q <= 1'b0;
         drop_q        <= 1'b0;
         pend_pc_q     <= '0;
         pend_taken_q  <= 1'b0;
         pend_target_q <= '0;
      end else begin
         pc_q          <= pc_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
         pend_pc_q     <= pend_pc_d;
         pend_taken_q  <= pend_taken_d;
         pend_target_q <= pend_target_d;
      end
   end

   fetch_queue #(.DEPTH(FQ_DEPTH)) u_queue (
      .clk       (clk),
      .reset     (reset),
      .clear     (flush),
      .push      (q_push),
      .push_data (q_in),
      .pop       (deq),
      .head      (q_head),
      .empty     (q_empty),
      .full      (q_full)
   );

   assign dec_pc          = q_head.pc;
   assign dec_instr       = q_head.instr;
   assign dec_pred_taken  = q_head.pred_taken;
   assign dec_pred_target = q_head.pred_target;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based reference model.
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam int          DEPTH  = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        predicted_taken = 1'b0, btb_hit = 1'b0, flush = 1'b0;
   logic [31:0] predicted_target = '0, recover_pc = '0;
   logic        imem_req_ready = 1'b0, imem_resp_valid = 1'b0, dec_ready = 1'b0;
   logic [31:0] imem_resp_data = '0;
   logic        fetch_valid, imem_req_valid, dec_valid, dec_pred_taken;
   logic [31:0] fetch_pc, imem_req_addr, dec_pc, dec_instr, dec_pred_target;

   fetch_unit #(.RESET_PC(RST_PC), .FQ_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
      .predicted_taken(predicted_taken), .predicted_target(predicted_target),
      .btb_hit(btb_hit), .flush(flush), .recover_pc(recover_pc),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
      .imem_resp_data(imem_resp_data), .dec_valid(dec_valid), .dec_ready(dec_ready),
      .dec_pc(dec_pc), .dec_instr(dec_instr), .dec_pred_taken(dec_pred_taken),
      .dec_pred_target(dec_pred_target)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // reference model state
   logic [31:0] m_pc, m_ppc, m_ptgt;
   logic        m_out, m_drop, m_ptk;
   fq_entry_t   m_q[$];

   // memory environment and logs
   logic        rand_mode = 1'b0, spurious_en = 1'b0, mem_busy = 1'b0, mem_fire = 1'b0;
   int          mem_cnt = 0, mem_lat = 0;
   logic [31:0] mem_data = '0;
   logic [31:0] acc_log[$];
   fq_entry_t   dec_log[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = RST_PC; m_out = 1'b0; m_drop = 1'b0;
      m_ppc = '0; m_ptk = 1'b0; m_ptgt = '0;
      m_q.delete();
   endtask

   task automatic compare_and_step();
      logic      exp_rv, exp_dv;
      fq_entry_t e;
      if (reset) model_reset();
      exp_rv = !reset && !flush && !m_out && !m_drop && (m_q.size() < DEPTH);
      exp_dv = (m_q.size() != 0) && !flush;
      chk("imem_req_valid", 32'(imem_req_valid), 32'(exp_rv));
      chk("fetch_valid", 32'(fetch_valid), 32'(exp_rv));
      chk("imem_req_addr", imem_req_addr, m_pc);
      chk("fetch_pc", fetch_pc, m_pc);
      chk("dec_valid", 32'(dec_valid), 32'(exp_dv));
      if (exp_dv) begin
         chk("dec_pc", dec_pc, m_q[0].pc);
         chk("dec_instr", dec_instr, m_q[0].instr);
         chk("dec_pred_taken", 32'(dec_pred_taken), 32'(m_q[0].pred_taken));
         chk("dec_pred_target", dec_pred_target, m_q[0].pred_target);
      end
      // environment: memory and logs follow the DUT handshakes
      if (reset) begin
         mem_busy = 1'b0;
      end else begin
         if (mem_fire) mem_busy = 1'b0;
         if (imem_req_valid && imem_req_ready) begin
            mem_busy = 1'b1;
            mem_cnt  = rand_mode ? int'($urandom_range(0, 3)) : mem_lat;
            mem_data = rand_mode ? $urandom : (32'h1000_0000 | imem_req_addr);
            acc_log.push_back(imem_req_addr);
         end
         if (dec_valid && dec_ready) begin
            e.pc = dec_pc; e.instr = dec_instr;
            e.pred_taken = dec_pred_taken; e.pred_target = dec_pred_target;
            dec_log.push_back(e);
         end
      end
      // model: advance by the rules for this cycle's inputs
      if (!reset) begin
         if (flush) begin
            m_drop = (m_out || m_drop) && !imem_resp_valid;
            m_out  = 1'b0;
            m_q.delete();
            m_pc   = recover_pc & 32'hFFFF_FFFC;
         end else begin
            if (exp_dv && dec_ready) void'(m_q.pop_front());
            if (imem_resp_valid) begin
               if (m_drop) begin
                  m_drop = 1'b0;
               end else if (m_out) begin
                  e.pc = m_ppc; e.instr = imem_resp_data;
                  e.pred_taken = m_ptk; e.pred_target = m_ptgt;
                  m_q.push_back(e);
                  m_out = 1'b0;
               end
            end
            if (exp_rv && imem_req_ready) begin
               m_ppc  = m_pc;
               m_ptk  = predicted_taken && btb_hit;
               m_ptgt = predicted_target;
               m_pc   = (m_ptk ? predicted_target : m_pc + 32'd4) & 32'hFFFF_FFFC;
               m_out  = 1'b1;
            end
         end
      end
   endtask

   task automatic env_drive();
      mem_fire = 1'b0;
      imem_resp_valid = 1'b0;
      if (mem_busy) begin
         if (mem_cnt == 0) begin
            mem_fire = 1'b1; imem_resp_valid = 1'b1; imem_resp_data = mem_data;
         end else begin
            mem_cnt--;
         end
      end else if (spurious_en && $urandom_range(0, 7) == 0) begin
         imem_resp_valid = 1'b1; imem_resp_data = $urandom;
      end
      if (rand_mode) begin
         predicted_taken  = 1'($urandom_range(0, 1));
         btb_hit          = 1'($urandom_range(0, 1));
         predicted_target = $urandom;
         imem_req_ready   = ($urandom_range(0, 9) < 7);
         dec_ready        = 1'($urandom_range(0, 1));
         flush            = ($urandom_range(0, 15) == 0);
         recover_pc       = $urandom;
         reset            = ($urandom_range(0, 299) == 0);
      end else begin
         predicted_taken  = (fetch_pc == 32'h40) || (fetch_pc == 32'h44);
         btb_hit          = (fetch_pc == 32'h40);
         predicted_target = (fetch_pc == 32'h40) ? 32'h80 : 32'h100;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      compare_and_step();
      @(posedge clk);
      #1;
      env_drive();
      #1;
   endtask

   initial begin
      model_reset();
      imem_req_ready = 1'b1;
      dec_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
      chk("rst_dec_valid", 32'(dec_valid), 32'd0);
      chk("rst_fetch_pc", fetch_pc, RST_PC);
      chk("rst_dec_pc", dec_pc, 32'd0);
      chk("rst_dec_instr", dec_instr, 32'd0);
      chk("rst_dec_target", dec_pred_target, 32'd0);
      reset = 1'b0;
      env_drive();
      #1;
      chk("first_req_valid", 32'(imem_req_valid), 32'd1);
      chk("first_req_addr", imem_req_addr, RST_PC);

      // sequential fetch, one-cycle memory
      for (int i = 0; i < 40 && (acc_log.size() < 3 || dec_log.size() < 3); i++) tick();
      chk("A_progress", 32'(acc_log.size() >= 3 && dec_log.size() >= 3), 32'd1);
      if (acc_log.size() >= 3 && dec_log.size() >= 3) begin
         for (int i = 0; i < 3; i++) begin
            chk("A_req_addr", acc_log[i], 32'(4 * i));
            chk("A_dec_pc", dec_log[i].pc, 32'(4 * i));
            chk("A_dec_instr", dec_log[i].instr, 32'h1000_0000 | 32'(4 * i));
            chk("A_dec_taken", 32'(dec_log[i].pred_taken), 32'd0);
         end
      end

      // taken prediction with BTB hit
      acc_log.delete(); dec_log.delete();
      dec_ready = 1'b0; flush = 1'b1; recover_pc = 32'h40;
      #1;
      chk("B_flush_req_valid", 32'(imem_req_valid), 32'd0);
      chk("B_flush_dec_valid", 32'(dec_valid), 32'd0);
      tick();
      flush = 1'b0;
      #1;
      for (int i = 0; i < 20 && acc_log.size() < 2; i++) tick();
      chk("B_progress", 32'(acc_log.size() >= 2), 32'd1);
      if (acc_log.size() >= 2) begin
         chk("B_req0", acc_log[0], 32'h40);
         chk("B_req1", acc_log[1], 32'h80);
      end
      chk("B_head_pc", dec_pc, 32'h40);
      chk("B_head_taken", 32'(dec_pred_taken), 32'd1);
      chk("B_head_target", dec_pred_target, 32'h80);

      // taken without BTB hit; misaligned recover address
      acc_log.delete();
      flush = 1'b1; recover_pc = 32'h47;
      #1;
      tick();
      flush = 1'b0;
      #1;
      for (int i = 0; i < 20 && acc_log.size() < 2; i++) tick();
      chk("C_progress", 32'(acc_log.size() >= 2), 32'd1);
      if (acc_log.size() >= 2) begin
         chk("C_req0", acc_log[0], 32'h44);
         chk("C_req1", acc_log[1], 32'h48);
      end
      chk("C_head_pc", dec_pc, 32'h44);
      chk("C_head_taken", 32'(dec_pred_taken), 32'd0);

      // queue full stalls fetch; one dequeue lets one request through
      repeat (16) tick();
      chk("D_full_req_valid", 32'(imem_req_valid), 32'd0);
      chk("D_full_dec_valid", 32'(dec_valid), 32'd1);
      acc_log.delete(); dec_log.delete();
      dec_ready = 1'b1;
      #1;
      tick();
      dec_ready = 1'b0;
      #1;
      repeat (6) tick();
      chk("D_dequeues", 32'(dec_log.size()), 32'd1);
      chk("D_resumed_reqs", 32'(acc_log.size()), 32'd1);
      if (dec_log.size() >= 1) chk("D_deq_pc", dec_log[0].pc, 32'h44);

      // flush while a request is outstanding: late response is dropped
      dec_ready = 1'b1; flush = 1'b1; recover_pc = 32'h48;
      #1;
      tick();
      flush = 1'b0; mem_lat = 2;
      #1;
      chk("E_req_valid", 32'(imem_req_valid), 32'd1);
      chk("E_req_addr", imem_req_addr, 32'h48);
      tick();
      flush = 1'b1; recover_pc = 32'h50;
      #1;
      tick();
      flush = 1'b0;
      #1;
      chk("E_drop_req_valid", 32'(imem_req_valid), 32'd0);
      tick();
      chk("E_late_resp", 32'(imem_resp_valid), 32'd1);
      chk("E_resp_req_valid", 32'(imem_req_valid), 32'd0);
      tick();
      chk("E_next_valid", 32'(imem_req_valid), 32'd1);
      chk("E_next_addr", imem_req_addr, 32'h50);
      chk("E_queue_empty", 32'(dec_valid), 32'd0);

      // PC wrap at the top of the address space
      acc_log.delete();
      mem_lat = 0; flush = 1'b1; recover_pc = 32'hFFFF_FFFF;
      #1;
      tick();
      flush = 1'b0;
      #1;
      for (int i = 0; i < 20 && acc_log.size() < 2; i++) tick();
      chk("F_progress", 32'(acc_log.size() >= 2), 32'd1);
      if (acc_log.size() >= 2) begin
         chk("F_req0", acc_log[0], 32'hFFFF_FFFC);
         chk("F_req1", acc_log[1], 32'h0000_0000);
      end

      // reset in the middle of fetching with entries queued
      dec_ready = 1'b0; flush = 1'b1; recover_pc = 32'h200;
      #1;
      tick();
      flush = 1'b0;
      #1;
      for (int i = 0; i < 30 && m_q.size() < 3; i++) tick();
      chk("G_filled", 32'(m_q.size() >= 3), 32'd1);
      chk("G_pre_dec_valid", 32'(dec_valid), 32'd1);
      reset = 1'b1;
      #1;
      chk("G_rst_dec_valid", 32'(dec_valid), 32'd0);
      chk("G_rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("G_rst_dec_pc", dec_pc, 32'd0);
      tick();
      reset = 1'b0;
      #1;
      chk("G_post_req_valid", 32'(imem_req_valid), 32'd1);
      chk("G_post_req_addr", imem_req_addr, RST_PC);

      // randomized traffic against the model
      rand_mode = 1'b1; spurious_en = 1'b1;
      repeat (3000) tick();
      rand_mode = 1'b0; spurious_en = 1'b0;
      reset = 1'b0; flush = 1'b0;
      #1;
      repeat (4) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
